// File: rtl/exec_pkg.sv
// Shared types for the execute stage: op codes, muldiv FSM states, ABI addresses.
package exec_pkg;

    typedef enum logic [4:0] {
        OP_ADD    = 5'd0,
        OP_SUB    = 5'd1,
        OP_AND    = 5'd2,
        OP_OR     = 5'd3,
        OP_XOR    = 5'd4,
        OP_SLT    = 5'd5,
        OP_SLTU   = 5'd6,
        OP_SLL    = 5'd7,
        OP_SRL    = 5'd8,
        OP_SRA    = 5'd9,
        OP_PASS   = 5'd10,
        OP_R11    = 5'd11,
        OP_R12    = 5'd12,
        OP_R13    = 5'd13,
        OP_R14    = 5'd14,
        OP_R15    = 5'd15,
        OP_MUL    = 5'd16,
        OP_MULH   = 5'd17,
        OP_MULHSU = 5'd18,
        OP_MULHU  = 5'd19,
        OP_DIV    = 5'd20,
        OP_DIVU   = 5'd21,
        OP_REM    = 5'd22,
        OP_REMU   = 5'd23,
        OP_R24    = 5'd24,
        OP_R25    = 5'd25,
        OP_R26    = 5'd26,
        OP_R27    = 5'd27,
        OP_R28    = 5'd28,
        OP_R29    = 5'd29,
        OP_R30    = 5'd30,
        OP_R31    = 5'd31
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_t;

    localparam int A0_ADDR = 10;

endpackage

// File: rtl/exec_unit_muldiv_seq.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle.
module muldiv_seq
    import exec_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [4:0]            op_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  logic [ADDR_WIDTH-1:0] rd_i,
    input  logic                  we_i,
    output logic                  ready_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic [ADDR_WIDTH-1:0] rd_o,
    output logic                  we_o
);
    localparam int DW = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [DW-1:0]   m;
    logic [2*DW-1:0] acc;
    logic            neg_q, neg_r, hi_sel, rem_sel, is_div, dz;

    logic            a_sgn, b_sgn, sa, sb;
    logic [DW-1:0]   a_mag, b_mag;
    logic [DW:0]     mul_sum, rem_sh, diff;
    logic            q_bit;
    logic [2*DW-1:0] prod;
    logic [DW-1:0]   quo, rem;

    always_comb begin
        a_sgn   = op_i[2] ? ~op_i[0] : (op_i[1:0] != 2'b11);
        b_sgn   = op_i[2] ? ~op_i[0] : ~op_i[1];
        sa      = a_sgn & a_i[DW-1];
        sb      = b_sgn & b_i[DW-1];
        a_mag   = sa ? -a_i : a_i;
        b_mag   = sb ? -b_i : b_i;
        mul_sum = {1'b0, acc[2*DW-1:DW]} + (acc[0] ? {1'b0, m} : '0);
        rem_sh  = {acc[2*DW-1:DW], acc[DW-1]};
        diff    = rem_sh - {1'b0, m};
        q_bit   = ~diff[DW];
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:     if (start_i) state_nxt = op_i[2] ? DIV : MUL;
            MUL, DIV: if (cnt == CW'(DW - 1)) state_nxt = FIX;
            FIX:      state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            cnt     <= '0;
            m       <= '0;
            acc     <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            hi_sel  <= 1'b0;
            rem_sel <= 1'b0;
            is_div  <= 1'b0;
            dz      <= 1'b0;
            rd_o    <= '0;
            we_o    <= 1'b0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: if (start_i) begin
                    cnt     <= '0;
                    m       <= op_i[2] ? b_mag : a_mag;
                    acc     <= {{DW{1'b0}}, op_i[2] ? a_mag : b_mag};
                    neg_q   <= sa ^ sb;
                    neg_r   <= sa;
                    hi_sel  <= op_i[1:0] != 2'b00;
                    rem_sel <= op_i[1];
                    is_div  <= op_i[2];
                    dz      <= b_i == '0;
                    rd_o    <= rd_i;
                    we_o    <= we_i;
                end
                MUL: begin
                    acc <= {mul_sum, acc[DW-1:1]};
                    cnt <= cnt + CW'(1);
                end
                DIV: begin
                    acc <= {q_bit ? diff[DW-1:0] : rem_sh[DW-1:0],
                            acc[DW-2:0], q_bit};
                    cnt <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    // Divide by zero forces all-ones quotient; remainder already equals dividend
    always_comb begin
        prod = neg_q ? -acc : acc;
        quo  = dz ? '1 : (neg_q ? -acc[DW-1:0] : acc[DW-1:0]);
        rem  = neg_r ? -acc[2*DW-1:DW] : acc[2*DW-1:DW];
        if (is_div) result_o = rem_sel ? rem : quo;
        else        result_o = hi_sel ? prod[2*DW-1:DW] : prod[DW-1:0];
    end

    assign ready_o = state == IDLE;
    assign done_o  = state == FIX;

endmodule

// File: rtl/exec_unit.sv
// Execute stage: register file, single-cycle ALU, optional iterative MUL/DIV.
// Define EXEC_MULDIV_EN to build in the muldiv engine.
module exec_unit
    import exec_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [4:0]            op_i,
    input  logic [ADDR_WIDTH-1:0] rs1_i,
    input  logic [ADDR_WIDTH-1:0] rs2_i,
    input  logic [ADDR_WIDTH-1:0] rd_i,
    input  logic                  reg_write_i,
    input  logic                  alu_src_i,
    input  logic [DATA_WIDTH-1:0] imm_op_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  eq_o,
    output logic [DATA_WIDTH-1:0] a0_o
);
    localparam int SW = $clog2(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] regs [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rs1_val, rs2_val, op2, alu_res, wr_data;
    logic [SW-1:0]         shamt;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic                  accept, res_ok, wr_en;

    assign rs1_val = regs[rs1_i];
    assign rs2_val = regs[rs2_i];
    assign op2     = alu_src_i ? imm_op_i : rs2_val;
    assign shamt   = op2[SW-1:0];
    assign accept  = valid_i && ready_o;
    assign a0_o    = regs[ADDR_WIDTH'(A0_ADDR)];

    always_comb begin
        alu_res = '0;
        unique case (op_t'(op_i))
            OP_ADD:  alu_res = rs1_val + op2;
            OP_SUB:  alu_res = rs1_val - op2;
            OP_AND:  alu_res = rs1_val & op2;
            OP_OR:   alu_res = rs1_val | op2;
            OP_XOR:  alu_res = rs1_val ^ op2;
            OP_SLT:  alu_res = DATA_WIDTH'($signed(rs1_val) < $signed(op2));
            OP_SLTU: alu_res = DATA_WIDTH'(rs1_val < op2);
            OP_SLL:  alu_res = rs1_val << shamt;
            OP_SRL:  alu_res = rs1_val >> shamt;
            OP_SRA:  alu_res = DATA_WIDTH'($signed(rs1_val) >>> shamt);
            OP_PASS: alu_res = op2;
            default: alu_res = '0;
        endcase
    end

`ifdef EXEC_MULDIV_EN
    logic                  md_start, md_done, md_we;
    logic [DATA_WIDTH-1:0] md_res;
    logic [ADDR_WIDTH-1:0] md_rd;

    assign md_start = accept && op_i[4] && !op_i[3];

    muldiv_seq #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_muldiv (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (md_start),
        .op_i     (op_i),
        .a_i      (rs1_val),
        .b_i      (op2),
        .rd_i     (rd_i),
        .we_i     (reg_write_i),
        .ready_o  (ready_o),
        .done_o   (md_done),
        .result_o (md_res),
        .rd_o     (md_rd),
        .we_o     (md_we)
    );
`else
    assign ready_o = 1'b1;
`endif

    always_comb begin
        res_ok  = accept;
        wr_en   = accept && reg_write_i;
        wr_addr = rd_i;
        wr_data = alu_res;
`ifdef EXEC_MULDIV_EN
        // A muldiv op only retires from FIX; ready_o is low there, so no clash
        if (md_start) begin
            res_ok = 1'b0;
            wr_en  = 1'b0;
        end
        if (md_done) begin
            res_ok  = 1'b1;
            wr_en   = md_we;
            wr_addr = md_rd;
            wr_data = md_res;
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 2**ADDR_WIDTH; i++) regs[i] <= '0;
            valid_o  <= 1'b0;
            result_o <= '0;
            eq_o     <= 1'b0;
        end else begin
            valid_o <= res_ok;
            if (res_ok) begin
                result_o <= wr_data;
                eq_o     <= wr_data == '0;
            end
            if (wr_en && wr_addr != '0) regs[wr_addr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_exec_unit.sv
// Directed self-checking bench for exec_unit (muldiv checks when EXEC_MULDIV_EN).
module tb_exec_unit;
    import exec_pkg::*;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          valid_i = 1'b0;
    logic          ready_o;
    logic [4:0]    op_i = '0;
    logic [AW-1:0] rs1_i = '0, rs2_i = '0, rd_i = '0;
    logic          reg_write_i = 1'b0;
    logic          alu_src_i = 1'b0;
    logic [DW-1:0] imm_op_i = '0;
    logic          valid_o;
    logic [DW-1:0] result_o;
    logic          eq_o;
    logic [DW-1:0] a0_o;

    int n_chk  = 0;
    int n_fail = 0;

    exec_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .op_i        (op_i),
        .rs1_i       (rs1_i),
        .rs2_i       (rs2_i),
        .rd_i        (rd_i),
        .reg_write_i (reg_write_i),
        .alu_src_i   (alu_src_i),
        .imm_op_i    (imm_op_i),
        .valid_o     (valid_o),
        .result_o    (result_o),
        .eq_o        (eq_o),
        .a0_o        (a0_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs,
                         input logic [DW-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one op, clock it in, drop valid; outputs then reflect that edge
    task automatic issue(input op_t op, input int rs1, input int rs2,
                         input int rd, input logic src,
                         input logic [DW-1:0] imm);
        valid_i     = 1'b1;
        op_i        = op;
        rs1_i       = AW'(rs1);
        rs2_i       = AW'(rs2);
        rd_i        = AW'(rd);
        reg_write_i = 1'b1;
        alu_src_i   = src;
        imm_op_i    = imm;
        step();
        valid_i = 1'b0;
    endtask

    task automatic alu(input string tag, input op_t op, input int rs1,
                       input int rs2, input int rd, input logic src,
                       input logic [DW-1:0] imm, input logic [DW-1:0] exp);
        issue(op, rs1, rs2, rd, src, imm);
        check({tag, ".valid"}, DW'(valid_o), DW'(1));
        check({tag, ".res"}, result_o, exp);
    endtask

`ifdef EXEC_MULDIV_EN
    task automatic md(input string tag, input op_t op, input int rs1,
                      input int rd, input logic [DW-1:0] imm,
                      input logic [DW-1:0] exp);
        int lat;
        int low;
        issue(op, rs1, 0, rd, 1'b1, imm);
        lat = 1;
        low = 0;
        while (!valid_o && lat < 60) begin
            if (!ready_o) low++;
            step();
            lat++;
        end
        check({tag, ".lat"}, DW'(lat), DW'(DW + 2));
        check({tag, ".busy"}, DW'(low), DW'(DW + 1));
        check({tag, ".ready"}, DW'(ready_o), DW'(1));
        check({tag, ".res"}, result_o, exp);
    endtask
`endif

    initial begin
        step();
        step();
        rst_i = 1'b0;
        check("rst.ready", DW'(ready_o), DW'(1));
        check("rst.valid", DW'(valid_o), DW'(0));
        check("rst.result", result_o, '0);
        check("rst.eq", DW'(eq_o), DW'(0));
        check("rst.a0", a0_o, '0);

        alu("pass_x1", OP_PASS, 0, 0, 1, 1'b1, 32'd5, 32'd5);
        check("pass_x1.eq", DW'(eq_o), DW'(0));
        alu("add_x2", OP_ADD, 1, 1, 2, 1'b0, '0, 32'd10);
        alu("add_x4", OP_ADD, 2, 2, 4, 1'b0, '0, 32'd20);
        alu("pass_a0", OP_PASS, 0, 0, 10, 1'b1, 32'd7, 32'd7);
        check("a0", a0_o, 32'd7);
        alu("sub_x3", OP_SUB, 1, 1, 3, 1'b0, '0, 32'd0);
        check("sub_x3.eq", DW'(eq_o), DW'(1));
        step();
        check("idle.valid", DW'(valid_o), DW'(0));

        alu("pass_x6", OP_PASS, 0, 0, 6, 1'b1, 32'hFFFF_FFF0, 32'hFFFF_FFF0);
        alu("sra", OP_SRA, 6, 0, 7, 1'b1, 32'd2, 32'hFFFF_FFFC);
        alu("srl", OP_SRL, 6, 0, 7, 1'b1, 32'd2, 32'h3FFF_FFFC);
        alu("slt", OP_SLT, 6, 1, 7, 1'b0, '0, 32'd1);
        alu("sltu", OP_SLTU, 6, 1, 7, 1'b0, '0, 32'd0);
        alu("sll", OP_SLL, 1, 0, 7, 1'b1, 32'd33, 32'd10);
        alu("xor", OP_XOR, 1, 0, 7, 1'b1, 32'hF, 32'hA);
        alu("and", OP_AND, 6, 0, 7, 1'b1, 32'h0F0F_0F3F, 32'h0F0F_0F30);
        alu("or", OP_OR, 1, 0, 7, 1'b1, 32'h30, 32'h35);
        alu("rsvd12", OP_R12, 1, 1, 7, 1'b0, '0, 32'd0);

        alu("add_x0", OP_ADD, 1, 0, 0, 1'b1, 32'd0, 32'd5);
        alu("read_x0", OP_ADD, 0, 0, 8, 1'b1, 32'd0, 32'd0);

`ifdef EXEC_MULDIV_EN
        alu("pass_m3", OP_PASS, 0, 0, 12, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFD);
        alu("pass_7", OP_PASS, 0, 0, 14, 1'b1, 32'd7, 32'd7);
        alu("pass_min", OP_PASS, 0, 0, 15, 1'b1, 32'h8000_0000, 32'h8000_0000);
        md("mul", OP_MUL, 12, 13, 32'd7, 32'hFFFF_FFEB);
        md("mulh", OP_MULH, 15, 16, 32'h8000_0000, 32'h4000_0000);
        md("mulhu", OP_MULHU, 12, 16, 32'd7, 32'h0000_0006);
        md("div0", OP_DIV, 14, 16, 32'd0, 32'hFFFF_FFFF);
        md("rem0", OP_REM, 14, 16, 32'd0, 32'd7);
        md("divovf", OP_DIV, 15, 16, 32'hFFFF_FFFF, 32'h8000_0000);
        md("removf", OP_REM, 15, 16, 32'hFFFF_FFFF, 32'd0);
        md("divneg", OP_DIV, 12, 16, 32'd2, 32'hFFFF_FFFF);
        alu("rd_x13", OP_ADD, 13, 0, 17, 1'b1, 32'd0, 32'hFFFF_FFEB);

        issue(OP_DIVU, 14, 0, 5, 1'b1, 32'd2);
        for (int i = 0; i < 9; i++) step();
        check("abort.busy", DW'(ready_o), DW'(0));
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        check("abort.ready", DW'(ready_o), DW'(1));
        check("abort.valid", DW'(valid_o), DW'(0));
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 40; i++) begin
                if (valid_o) seen++;
                step();
            end
            check("abort.novalid", DW'(seen), DW'(0));
        end
        alu("abort.x5", OP_ADD, 5, 0, 17, 1'b1, 32'd0, 32'd0);
`else
        alu("mul_off", OP_MUL, 1, 1, 9, 1'b0, '0, 32'd0);
        check("mul_off.ready", DW'(ready_o), DW'(1));
        alu("div_off", OP_DIV, 1, 0, 9, 1'b1, 32'd1, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
